// File: rtl/chebyshev_sequencer_if.sv
// Handshake bundle between the argument source / coefficient MAC and the
// Chebyshev term sequencer.
interface chebyshev_sequencer_if #(
  parameter int WL                    = 12,
  parameter int I_BITS                = 6,
  parameter int BOUNDARY_BIT_POSITION = 3,
  parameter int ORD_W                 = 4
);
  localparam int O_BITS = WL - (I_BITS - BOUNDARY_BIT_POSITION);

  logic              start;
  logic [WL-1:0]     x_in;
  logic [ORD_W-1:0]  order_in;
  logic              busy;
  logic [O_BITS-1:0] term_out;
  logic [ORD_W-1:0]  term_idx;
  logic              term_valid;
  logic              term_ready;
  logic              done;

  // Requester side: issues start/argument and accepts terms.
  modport master (
    output start, x_in, order_in, term_ready,
    input  busy, term_out, term_idx, term_valid, done
  );

  // Sequencer side.
  modport slave (
    input  start, x_in, order_in, term_ready,
    output busy, term_out, term_idx, term_valid, done
  );
endinterface

// File: rtl/chebyshev_sequencer.sv
// Sequential Chebyshev series evaluator: T_0..T_N of one fixed-point x via
// T_{k+1} = 2*x*T_k - T_{k-1}, one saturated term streamed per handshake.
module chebyshev_sequencer #(
  parameter int WL                    = 12,
  parameter int I_BITS                = 6,
  parameter int BOUNDARY_BIT_POSITION = 3,
  parameter int ORD_W                 = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  chebyshev_sequencer_if.slave  bus
);
  localparam int F         = WL - I_BITS;
  localparam int O_BITS    = WL - (I_BITS - BOUNDARY_BIT_POSITION);
  localparam int ACC_W     = WL + O_BITS + 1;
  localparam int SAT_MAX_I = (2 ** (O_BITS - 1)) - 1;
  localparam int SAT_MIN_I = -(2 ** (O_BITS - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_I);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(SAT_MIN_I);
  localparam logic [O_BITS-1:0]       ONE     = O_BITS'(2 ** F);

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

  state_t                   state;
  logic signed [WL-1:0]     x_r;
  logic [ORD_W-1:0]         n_r;
  logic [ORD_W-1:0]         k;
  logic signed [O_BITS-1:0] t_m1;
  logic signed [O_BITS-1:0] t_m2;
  logic                     busy;
  logic [O_BITS-1:0]        term_out;
  logic [ORD_W-1:0]         term_idx;
  logic                     term_valid;
  logic                     done;

  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  diff;
  logic [O_BITS-1:0]        calc_val;

  function automatic logic [O_BITS-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[O_BITS-1:0];
    else if (v < SAT_MIN) return SAT_MIN[O_BITS-1:0];
    else                  return v[O_BITS-1:0];
  endfunction

  // Shared multiply/shift/subtract path; operands sign-extended to ACC_W so
  // the doubled product and the subtraction cannot overflow.
  always_comb begin
    prod = ACC_W'(x_r) * ACC_W'(t_m1);
    diff = ((prod <<< 1) >>> F) - ACC_W'(t_m2);
    if (k == '0)
      calc_val = ONE;
    else if (k == ORD_W'(1))
      calc_val = sat(ACC_W'(x_r));
    else
      calc_val = sat(diff);
  end

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_r        <= '0;
      n_r        <= '0;
      k          <= '0;
      t_m1       <= '0;
      t_m2       <= '0;
      busy       <= 1'b0;
      term_out   <= '0;
      term_idx   <= '0;
      term_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_r   <= $signed(bus.x_in);
            n_r   <= bus.order_in;
            k     <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          term_out   <= calc_val;
          term_idx   <= k;
          term_valid <= 1'b1;
          state      <= EMIT;
        end
        EMIT: begin
          if (bus.term_ready) begin
            term_valid <= 1'b0;
            if (k == n_r) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              t_m2  <= t_m1;
              t_m1  <= $signed(term_out);
              k     <= k + ORD_W'(1);
              state <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.term_out   = term_out;
  assign bus.term_idx   = term_idx;
  assign bus.term_valid = term_valid;
  assign bus.done       = done;
endmodule

// File: tb/tb_chebyshev_sequencer.sv
// Self-checking bench for chebyshev_sequencer: directed and random runs
// against an integer-arithmetic model of the Chebyshev recurrence.
module tb_chebyshev_sequencer;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   exp_t[16];

  chebyshev_sequencer_if #(.WL(12), .I_BITS(6), .BOUNDARY_BIT_POSITION(3), .ORD_W(4)) bif ();

  chebyshev_sequencer #(.WL(12), .I_BITS(6), .BOUNDARY_BIT_POSITION(3), .ORD_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  // Reference: T0 = 1.0 (64 LSB), T1 = sat(x), Tk = sat(floor(2*x*T(k-1)/64) - T(k-2)).
  task automatic model(input int x, input int n);
    int p;
    int q;
    exp_t[0] = 64;
    if (n >= 1) exp_t[1] = sat(x);
    for (int k = 2; k <= n; k++) begin
      p = 2 * x * exp_t[k-1];
      q = p / 64;
      if ((p % 64 != 0) && (p < 0)) q = q - 1;
      exp_t[k] = sat(q - exp_t[k-2]);
    end
  endtask

  function automatic logic signed [31:0] tout();
    return 32'($signed(bif.term_out));
  endfunction

  // Full evaluation with optional stall on one term and optional start
  // pulse while busy; start is also asserted during the final handshake.
  task automatic run_seq(input logic signed [11:0] x, input int n, input int stall_k,
                         input int stall_len, input bit inj);
    model(int'(x), n);
    bif.x_in       = x;
    bif.order_in   = 4'(n);
    bif.start      = 1'b1;
    bif.term_ready = 1'b1;
    step();
    bif.start = 1'b0;
    bif.x_in  = ~x;
    check("busy_after_start", 32'(bif.busy), 1);
    check("valid_after_1cyc", 32'(bif.term_valid), 0);
    for (int k = 0; k <= n; k++) begin
      step();
      check("term_valid", 32'(bif.term_valid), 1);
      check("term_out", tout(), exp_t[k]);
      check("term_idx", 32'(bif.term_idx), k);
      if (k == stall_k) begin
        bif.term_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          check("stall_valid", 32'(bif.term_valid), 1);
          check("stall_out", tout(), exp_t[k]);
          check("stall_idx", 32'(bif.term_idx), k);
        end
        bif.term_ready = 1'b1;
      end
      if (k == n) begin
        bif.start = 1'b1;
        bif.x_in  = 12'($urandom_range(0, 4095));
      end else if (inj && k == 1) begin
        bif.start = 1'b1;
        bif.x_in  = x + 12'sd100;
      end
      step();
      bif.start = 1'b0;
      check("valid_after_hs", 32'(bif.term_valid), 0);
      check("done_after_hs", 32'(bif.done), (k == n) ? 1 : 0);
      check("busy_after_hs", 32'(bif.busy), (k == n) ? 0 : 1);
    end
    step();
    check("done_single_pulse", 32'(bif.done), 0);
    check("busy_idle", 32'(bif.busy), 0);
    check("valid_idle", 32'(bif.term_valid), 0);
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    rst_n          = 1'b0;
    bif.start      = 1'b1;
    bif.x_in       = 12'sd32;
    bif.order_in   = 4'd3;
    bif.term_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_busy", 32'(bif.busy), 0);
      check("rst_valid", 32'(bif.term_valid), 0);
      check("rst_done", 32'(bif.done), 0);
    end
    check("rst_term_out", tout(), 0);
    check("rst_term_idx", 32'(bif.term_idx), 0);
    bif.start = 1'b0;
    rst_n     = 1'b1;
    step();

    // Basic, saturation, back-pressure, edge orders, ignored start.
    run_seq(12'sd32, 3, -1, 0, 1'b0);
    run_seq(12'sd192, 3, -1, 0, 1'b0);
    run_seq(-12'sd512, 1, -1, 0, 1'b0);
    run_seq(12'sd32, 2, 1, 5, 1'b0);
    run_seq(12'sd32, 0, -1, 0, 1'b0);
    run_seq(12'sd32, 3, -1, 0, 1'b1);
    run_seq(-12'sd70, 15, 15, 3, 1'b1);

    // Reset while T_2 of an N=5 run is being offered.
    bif.x_in       = 12'sd40;
    bif.order_in   = 4'd5;
    bif.term_ready = 1'b1;
    bif.start      = 1'b1;
    step();
    bif.start = 1'b0;
    step();
    step();
    step();
    step();
    bif.term_ready = 1'b0;
    step();
    check("pre_rst_idx", 32'(bif.term_idx), 2);
    check("pre_rst_valid", 32'(bif.term_valid), 1);
    rst_n          = 1'b0;
    bif.term_ready = 1'b1;
    step();
    check("midrst_busy", 32'(bif.busy), 0);
    check("midrst_valid", 32'(bif.term_valid), 0);
    check("midrst_done", 32'(bif.done), 0);
    check("midrst_out", tout(), 0);
    check("midrst_idx", 32'(bif.term_idx), 0);
    rst_n = 1'b1;
    step();
    check("postrst_done", 32'(bif.done), 0);
    run_seq(12'sd40, 5, -1, 0, 1'b0);

    // Random arguments and orders.
    for (int r = 0; r < 8; r++) begin
      run_seq(12'($urandom_range(0, 4095)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
